// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding, ready levels and op decode helpers for the EX-stage mul/div unit.
`define MdResultReady    1'b1
`define MdResultNotReady 1'b0

package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BYZERO = 2'b01;
    localparam logic [1:0] ON     = 2'b10;
    localparam logic [1:0] END    = 2'b11;

    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX <-> mul/div handshake: EX holds start_i with operands until ready_o, then drops it.
interface ex_muldiv_if #(parameter int unsigned WIDTH = 32);

    logic                 start_i;
    logic [1:0]           op_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 div_by_zero_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, busy_o, div_by_zero_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, busy_o, div_by_zero_o
    );

endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
module muldiv_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    output logic [WIDTH-1:0] y_c
);

    assign y_c = en ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide for EX: one result bit per cycle, {HI,LO} returned with ready_o.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]       state, state_nxt;
    logic [1:0]       op_r, op_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] b_r, b_nxt;
    logic [W2-1:0]    acc, acc_nxt, acc_iter;
    logic [W2-1:0]    result_r, result_nxt;
    logic             s1_r, s1_nxt, s2_r, s2_nxt, dz_r, dz_nxt;
    logic             ready_r, ready_nxt, busy_r, busy_nxt, dbz_r, dbz_nxt;

    logic             in_signed_c, fix_signed_c;
    logic [WIDTH-1:0] abs1_c, abs2_c, quo_c, rem_c;
    logic [W2-1:0]    prod_c;
    logic [WIDTH:0]   part_c, diff_c, sum_c;

    assign in_signed_c  = md_is_signed(bus.op_i);
    assign fix_signed_c = md_is_signed(op_r);

    muldiv_negate #(.WIDTH(WIDTH)) u_abs1 (
        .a(bus.opdata1_i), .en(in_signed_c & bus.opdata1_i[WIDTH-1]), .y_c(abs1_c));
    muldiv_negate #(.WIDTH(WIDTH)) u_abs2 (
        .a(bus.opdata2_i), .en(in_signed_c & bus.opdata2_i[WIDTH-1]), .y_c(abs2_c));
    muldiv_negate #(.WIDTH(W2)) u_prod (
        .a(acc_iter), .en(fix_signed_c & (s1_r ^ s2_r)), .y_c(prod_c));
    muldiv_negate #(.WIDTH(WIDTH)) u_quo (
        .a(acc_iter[WIDTH-1:0]), .en(fix_signed_c & (s1_r ^ s2_r)), .y_c(quo_c));
    muldiv_negate #(.WIDTH(WIDTH)) u_rem (
        .a(acc_iter[W2-1:WIDTH]), .en(fix_signed_c & s1_r), .y_c(rem_c));

    // One iteration: restoring subtract for divide, add-and-shift-right for multiply
    always_comb begin
        part_c = acc[W2-1:WIDTH-1];
        diff_c = part_c - {1'b0, b_r};
        sum_c  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);
        if (md_is_div(op_r)) begin
            acc_iter = diff_c[WIDTH] ? {acc[W2-2:0], 1'b0}
                                     : {diff_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_iter = {sum_c, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_nxt  = state;
        op_nxt     = op_r;
        cnt_nxt    = cnt;
        b_nxt      = b_r;
        acc_nxt    = acc;
        s1_nxt     = s1_r;
        s2_nxt     = s2_r;
        dz_nxt     = dz_r;
        result_nxt = result_r;

        if (bus.annul_i) begin
            state_nxt  = IDLE;
            result_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    result_nxt = '0;
                    if (bus.start_i) begin
                        op_nxt  = bus.op_i;
                        s1_nxt  = in_signed_c & bus.opdata1_i[WIDTH-1];
                        s2_nxt  = in_signed_c & bus.opdata2_i[WIDTH-1];
                        cnt_nxt = '0;
                        if (md_is_div(bus.op_i) && (bus.opdata2_i == '0)) begin
                            state_nxt = BYZERO;
                            dz_nxt    = 1'b1;
                        end else begin
                            state_nxt = ON;
                            dz_nxt    = 1'b0;
                            // Accumulator low half holds dividend / multiplier; b_r the other operand
                            acc_nxt   = {WIDTH'(0), md_is_div(bus.op_i) ? abs1_c : abs2_c};
                            b_nxt     = md_is_div(bus.op_i) ? abs2_c : abs1_c;
                        end
                    end
                end
                ON: begin
                    if (!bus.start_i) begin
                        state_nxt  = IDLE;
                        result_nxt = '0;
                    end else begin
                        acc_nxt = acc_iter;
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state_nxt  = END;
                            result_nxt = md_is_div(op_r) ? {rem_c, quo_c} : prod_c;
                        end
                    end
                end
                BYZERO: begin
                    state_nxt  = bus.start_i ? END : IDLE;
                    result_nxt = '0;
                end
                default: begin
                    if (!bus.start_i) begin
                        state_nxt  = IDLE;
                        result_nxt = '0;
                    end
                end
            endcase
        end

        ready_nxt = ((state == END) && (state_nxt == END)) ? `MdResultReady : `MdResultNotReady;
        dbz_nxt   = ready_nxt & dz_r;
        busy_nxt  = (state_nxt == ON) || (state_nxt == BYZERO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r     <= '0;
            cnt      <= '0;
            b_r      <= '0;
            acc      <= '0;
            s1_r     <= 1'b0;
            s2_r     <= 1'b0;
            dz_r     <= 1'b0;
            result_r <= '0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            op_r     <= op_nxt;
            cnt      <= cnt_nxt;
            b_r      <= b_nxt;
            acc      <= acc_nxt;
            s1_r     <= s1_nxt;
            s2_r     <= s2_nxt;
            dz_r     <= dz_nxt;
            result_r <= result_nxt;
            ready_r  <= ready_nxt;
            busy_r   <= busy_nxt;
            dbz_r    <= dbz_nxt;
        end
    end

    assign bus.result_o      = result_r;
    assign bus.ready_o       = ready_r;
    assign bus.busy_o        = busy_r;
    assign bus.div_by_zero_o = dbz_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv at WIDTH=32 and WIDTH=8: drivers push expected results, monitors pop on ready_o.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t exp32[$];
    exp_t exp8[$];
    int   start32, start8;
    logic rdy32_q = 1'b0, rdy8_q = 1'b0;

    ex_muldiv_if #(.WIDTH(32)) bus32 ();
    ex_muldiv_if #(.WIDTH(8))  bus8 ();

    ex_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    ex_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: compare on every rising ready_o
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            rdy32_q = 1'b0;
        end else begin
            if (bus32.ready_o && !rdy32_q) begin
                if (exp32.size() == 0) begin
                    check("w32_unexpected_ready", 64'd1, 64'd0);
                end else begin
                    e = exp32.pop_front();
                    check("w32_result", bus32.result_o, e.res);
                    check("w32_div_by_zero", 64'(bus32.div_by_zero_o), 64'(e.dz));
                    check("w32_latency", 64'(cyc - start32), 64'(e.lat));
                end
            end
            rdy32_q = bus32.ready_o;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            rdy8_q = 1'b0;
        end else begin
            if (bus8.ready_o && !rdy8_q) begin
                if (exp8.size() == 0) begin
                    check("w8_unexpected_ready", 64'd1, 64'd0);
                end else begin
                    e = exp8.pop_front();
                    check("w8_result", 64'(bus8.result_o), e.res);
                    check("w8_div_by_zero", 64'(bus8.div_by_zero_o), 64'(e.dz));
                    check("w8_latency", 64'(cyc - start8), 64'(e.lat));
                end
            end
            rdy8_q = bus8.ready_o;
        end
    end

    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] er, input logic edz, input int lat,
                         input int ebusy, input int hold);
        int busy_n = 0;
        bit seen = 0;
        @(negedge clk);
        bus32.op_i      = op;
        bus32.opdata1_i = a;
        bus32.opdata2_i = b;
        bus32.start_i   = 1'b1;
        exp32.push_back(exp_t'{er, edz, lat});
        start32 = cyc + 1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus32.op_i      = ~op;
                bus32.opdata1_i = ~a;
                bus32.opdata2_i = a ^ b;
            end
            if (bus32.busy_o)  busy_n++;
            if (bus32.ready_o) seen = 1;
        end
        if (!seen) check("w32_ready_timeout", 64'd0, 64'd1);
        check("w32_busy_cycles", 64'(busy_n), 64'(ebusy));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("w32_hold_ready", 64'(bus32.ready_o), 64'd1);
            check("w32_hold_result", bus32.result_o, er);
        end
        bus32.start_i = 1'b0;
        @(negedge clk);
        check("w32_drop_ready", 64'(bus32.ready_o), 64'd0);
        check("w32_drop_result", bus32.result_o, 64'd0);
        check("w32_drop_dbz", 64'(bus32.div_by_zero_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b0;
        bus32.start_i = 1'b0; bus32.op_i = 2'b00; bus32.annul_i = 1'b0;
        bus32.opdata1_i = '0; bus32.opdata2_i = '0;
        bus8.start_i = 1'b0;  bus8.op_i = 2'b00;  bus8.annul_i = 1'b0;
        bus8.opdata1_i = '0;  bus8.opdata2_i = '0;
        #1;
        check("reset_result", bus32.result_o, 64'd0);
        check("reset_ready", 64'(bus32.ready_o), 64'd0);
        check("reset_busy", 64'(bus32.busy_o), 64'd0);
        check("reset_dbz", 64'(bus32.div_by_zero_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run32(MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 33, 32, 5);
        run32(MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33, 32, 0);
        run32(MD_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 33, 32, 0);
        run32(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 33, 32, 0);
        run32(MD_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 33, 32, 0);
        run32(MD_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 33, 32, 0);
        run32(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 33, 32, 0);
        run32(MD_DIV, 32'd5, 32'd0, 64'd0, 1'b1, 2, 1, 2);

        // Annul mid-divide: unit returns idle and never reports ready
        @(negedge clk);
        bus32.op_i = MD_DIVU; bus32.opdata1_i = 32'd1000; bus32.opdata2_i = 32'd3;
        bus32.start_i = 1'b1;
        repeat (10) @(negedge clk);
        check("annul_busy_before", 64'(bus32.busy_o), 64'd1);
        bus32.annul_i = 1'b1;
        @(negedge clk);
        bus32.annul_i = 1'b0;
        bus32.start_i = 1'b0;
        check("annul_busy_after", 64'(bus32.busy_o), 64'd0);
        check("annul_ready_after", 64'(bus32.ready_o), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus32.ready_o) seen = 1;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        run32(MD_MULTU, 32'd3, 32'd4, 64'd12, 1'b0, 33, 32, 0);

        // Annul together with start in IDLE: nothing starts
        @(negedge clk);
        bus32.op_i = MD_DIVU; bus32.opdata1_i = 32'd9; bus32.opdata2_i = 32'd3;
        bus32.start_i = 1'b1; bus32.annul_i = 1'b1;
        @(negedge clk);
        check("annul_start_busy", 64'(bus32.busy_o), 64'd0);
        bus32.start_i = 1'b0; bus32.annul_i = 1'b0;
        @(negedge clk);
        check("annul_start_busy2", 64'(bus32.busy_o), 64'd0);
        check("annul_start_ready", 64'(bus32.ready_o), 64'd0);

        // Asynchronous reset in the middle of ON, away from any clock edge
        @(negedge clk);
        bus32.op_i = MD_DIVU; bus32.opdata1_i = 32'd100; bus32.opdata2_i = 32'd7;
        bus32.start_i = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_busy_before", 64'(bus32.busy_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_busy", 64'(bus32.busy_o), 64'd0);
        check("rst_async_ready", 64'(bus32.ready_o), 64'd0);
        check("rst_async_result", bus32.result_o, 64'd0);
        check("rst_async_dbz", 64'(bus32.div_by_zero_o), 64'd0);
        bus32.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_busy", 64'(bus32.busy_o), 64'd0);

        // WIDTH=8 instance: DIVU 200 / 3
        @(negedge clk);
        bus8.op_i = MD_DIVU; bus8.opdata1_i = 8'd200; bus8.opdata2_i = 8'd3;
        bus8.start_i = 1'b1;
        exp8.push_back(exp_t'{64'h0242, 1'b0, 9});
        start8 = cyc + 1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus8.ready_o) seen = 1;
        end
        if (!seen) check("w8_ready_timeout", 64'd0, 64'd1);
        bus8.start_i = 1'b0;
        @(negedge clk);
        check("w8_drop_ready", 64'(bus8.ready_o), 64'd0);
        check("w8_drop_result", 64'(bus8.result_o), 64'd0);

        repeat (5) @(negedge clk);
        check("w32_scoreboard_empty", 64'(exp32.size()), 64'd0);
        check("w8_scoreboard_empty", 64'(exp8.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the EX stage.
- Generalises the current divide-only handshake block to a configurable operand width, and adds multiply modes, an explicit divide-by-zero path and pipeline-flush annul.
- EX drives operands and holds start_i while it stalls. The unit returns {HI,LO} on result_o and raises ready_o.
- One result bit is produced per cycle: shift-subtract for divide, shift-add for multiply.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start_i  in  1  request. Held high by EX until ready_o is seen, then dropped.
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with start_i in IDLE.
- opdata1_i  in  WIDTH  multiplicand / dividend.
- opdata2_i  in  WIDTH  multiplier / divisor.
- annul_i  in  1  flush from exception or branch. Aborts any operation.
- result_o  out  2*WIDTH  DIV: {remainder, quotient}; MULT: {hi, lo} product.
- ready_o  out  1  result valid.
- busy_o  out  1  high in ON and BYZERO.
- div_by_zero_o  out  1  high with ready_o when a divide had divisor 0.

Behaviour:
- Reset, asynchronous on rst=0: state IDLE; result_o=0; ready_o=0; busy_o=0; div_by_zero_o=0; counter=0; operand registers cleared.
- States: IDLE, BYZERO, ON, END.
- IDLE, start_i=1 and annul_i=0:
  - Latch op_i and the operand magnitudes. In signed modes a negative operand is two's-complement negated; treat it as WIDTH-bit unsigned, so the most-negative value stays 2^(WIDTH-1).
  - Latch sign flags.
  - Divide with opdata2_i=0 goes to BYZERO; otherwise go to ON with counter=0.
- IDLE with start_i=0: stay; outputs 0.
- ON: one iteration per cycle; counter increments. After the WIDTH-th iteration (counter==WIDTH-1 this cycle), go to END.
  - Divide: restoring radix-2. Shift the dividend MSB into the partial remainder. Subtract the divisor if no borrow; the quotient bit is !borrow.
  - Multiply: if multiplier LSB=1, add the multiplicand into the upper half of the accumulator; shift right by 1.
- Sign fix, applied on entry to END (registered):
  - Signed divide: quotient is negated iff operand signs differ; remainder takes the dividend's sign.
  - Signed multiply: the 2*WIDTH product is negated iff signs differ.
  - Unsigned modes: no fix.
- Divide overflow: most-negative / -1 yields quotient 0x80000000 and remainder 0 at WIDTH=32. This is defined behaviour; there is no exception.
- BYZERO: go to END next cycle with result_o=0 and div_by_zero_o=1.
- END: ready_o=1 and result_o holds stable for as long as start_i stays 1. When start_i=0, go to IDLE next cycle; ready_o, result_o and div_by_zero_o return to 0.
- Latency: start sampled at edge N gives ready_o=1 after edge N+WIDTH+1, i.e. 33 cycles at WIDTH=32. Divide-by-zero gives ready_o after edge N+2.
- annul_i=1, any state: next state IDLE; outputs cleared next cycle. Annul wins over a simultaneous start_i; no operation starts that cycle.
- start_i dropped during ON or BYZERO: treated as abort, go to IDLE.
- Operand or op_i changes after capture are ignored until the next IDLE start.
- Reset mid-operation: immediate return to IDLE with outputs cleared; no partial result is visible.

Decomposition:
- Shared package muldiv_pkg holds:
  - op codes MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state encoding IDLE, BYZERO, ON, END (2-bit);
  - macros MdResultReady and MdResultNotReady, consistent with the existing div-ready defines.
- One sub-module is natural: muldiv_negate, a parametrised conditional two's-complement (width, enable) used for operand abs and result sign fix.

Test Plan:
- DIVU 100 / 7, WIDTH=32, start held -> ready_o after 33 cycles; result_o = {32'd2, 32'd14}; div_by_zero_o=0.
- DIV -7 / 2 -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}, i.e. remainder -1, quotient -3. Also DIV 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
- MULT 0x80000000 * 0x80000000 -> result_o = 64'h4000000000000000. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> 64'hFFFFFFFE00000001.
- DIV 5 / 0 -> ready_o after 2 cycles; result_o=0; div_by_zero_o=1; busy_o high for 1 cycle.
- annul_i pulse at iteration 10 of DIVU -> IDLE next cycle; ready_o never rises. A new start of MULTU 3*4 then completes with 64'd12 after 33 cycles. annul_i together with start_i in IDLE -> no busy_o.
- rst=0 mid-ON with no clock edge -> all outputs 0 immediately. Also: start_i held high in END for 5 cycles keeps ready_o and result_o stable; dropping start_i clears them next cycle. Repeat at WIDTH=8: DIVU 200/3 -> {8'd2, 8'd66} after 9 cycles.
